tree_path_engine: RTL and testbench

- Runtime tree builder and lookup engine for message-identifier hierarchies.
- Replaces elaboration-time tree generation with a clocked node table that accepts identifier paths streamed one level per beat.
- Each path either inserts missing nodes (INSERT) or resolves to a node address (LOOKUP).
- Sits between the message-header parser (upstream) and the field-dispatch logic (downstream, consumes node addresses).

---
 rtl/tree_engine_pkg.sv | 50 +++++
 rtl/tree_node_table.sv | 90 +++++++++
 rtl/tree_path_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_tree_path_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tree_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_engine_pkg
// Description : Shared types and helpers for the tree path engine.
//               - op_e    : path operation (LOOKUP / INSERT)
//               - err_e   : response error code
//               - state_e : engine FSM state encoding
//               - helpers : child-slot empty test and last-slot test
//               The node record itself depends on instance parameters and
//               is declared as a packed struct inside tree_node_table.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_engine_pkg;

  // Widest node address the helpers accept; callers size-cast into it.
  localparam int PKG_ADDR_W_MAX = 32;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK          = 2'd0,
    ERR_TABLE_FULL  = 2'd1,
    ERR_FANOUT_FULL = 2'd2,
    ERR_BAD_ID      = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ALLOC = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // A child slot is empty when it holds address 0: the root can never be a
  // child, so 0 is free to act as the "no child" marker.
  function automatic logic slot_is_empty(input logic [PKG_ADDR_W_MAX-1:0] addr);
    return (addr == '0);
  endfunction

  function automatic logic slot_is_last(input logic [31:0] k,
                                        input logic [31:0] max_children);
    return (k == max_children - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tree_node_table.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_table
// Description : Register array holding the tree nodes. Each node carries its
//               identifier, its parent address and MAX_CHILDREN child slots.
// Ports       : clk, rst_n        clock, async active-low reset
//               clear_i           synchronous clear of the whole table
//               rd_node_i/slot_i  read port: node address and child slot
//               rd_child_addr_o   address stored in that slot (0 = empty)
//               rd_child_id_o     identifier of the node that slot points to
//               wr_en_i           create node wr_node_i {wr_id_i, parent
//                                 wr_parent_i, no children} and link it into
//                                 slot wr_slot_i of wr_parent_i
// Revision    : 1.0 - initial release
// ============================================================================
module tree_node_table
  import tree_engine_pkg::*;
#(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE  = 8,
  parameter int MAX_NODES       = 64,
  parameter int MAX_CHILDREN    = 4,
  localparam int IDX_W  = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
  localparam int SLOT_W = (MAX_CHILDREN > 1) ? $clog2(MAX_CHILDREN) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic [NODE_ADDR_SIZE-1:0]  rd_node_i,
  input  logic [SLOT_W-1:0]          rd_slot_i,
  output logic [NODE_ADDR_SIZE-1:0]  rd_child_addr_o,
  output logic [IDENTIFIER_SIZE-1:0] rd_child_id_o,
  input  logic                       wr_en_i,
  input  logic [NODE_ADDR_SIZE-1:0]  wr_node_i,
  input  logic [IDENTIFIER_SIZE-1:0] wr_id_i,
  input  logic [NODE_ADDR_SIZE-1:0]  wr_parent_i,
  input  logic [SLOT_W-1:0]          wr_slot_i
);

  typedef struct packed {
    logic [IDENTIFIER_SIZE-1:0]                   id;
    logic [NODE_ADDR_SIZE-1:0]                    parent;
    logic [MAX_CHILDREN-1:0][NODE_ADDR_SIZE-1:0]  child;
  } node_t;

  node_t nodes_q [MAX_NODES];

  logic [IDX_W-1:0]          rd_idx;
  logic [IDX_W-1:0]          child_idx;
  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          par_idx;
  logic [NODE_ADDR_SIZE-1:0] child_addr;
  logic                      unused_bits;

  // Addresses never exceed MAX_NODES-1, so only the low index bits matter.
  assign rd_idx    = rd_node_i[IDX_W-1:0];
  assign wr_idx    = wr_node_i[IDX_W-1:0];
  assign par_idx   = wr_parent_i[IDX_W-1:0];
  assign child_idx = child_addr[IDX_W-1:0];

  // Chained read: slot contents, then the id of the node it points to, so
  // the engine can test one slot per cycle.
  always_comb begin
    child_addr      = nodes_q[rd_idx].child[rd_slot_i];
    rd_child_addr_o = child_addr;
    rd_child_id_o   = nodes_q[child_idx].id;
  end

  // Parent links are kept for downstream visibility only; the search never
  // walks upward. High address bits above the index are always zero.
  assign unused_bits = ^{nodes_q[rd_idx].parent, rd_node_i, child_addr,
                         wr_node_i, wr_parent_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NODES; i++) nodes_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < MAX_NODES; i++) nodes_q[i] <= '0;
    end else if (wr_en_i) begin
      // New node index is always above its parent, so the two writes never
      // target the same entry.
      nodes_q[wr_idx].id                  <= wr_id_i;
      nodes_q[wr_idx].parent              <= wr_parent_i;
      nodes_q[wr_idx].child               <= '0;
      nodes_q[par_idx].child[wr_slot_i]   <= wr_node_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tree_path_engine.sv
`default_nettype none
// ============================================================================
// Module      : tree_path_engine
// Description : Runtime tree builder / lookup engine. Identifier paths arrive
//               one level per beat; each path either resolves to a node
//               address (LOOKUP) or creates missing nodes (INSERT).
// Ports       : clk, rst_n             clock, async active-low reset
//               clear                  synchronous table clear, aborts path
//               cmd_valid/ready        path beat handshake
//               cmd_op                 0=LOOKUP 1=INSERT (first beat only)
//               cmd_id, cmd_last       level identifier, final beat flag
//               rsp_valid/ready        result handshake
//               rsp_hit                every level already existed
//               rsp_addr               deepest node address (0 on miss/err)
//               rsp_err                0 OK, 1 TABLE_FULL, 2 FANOUT_FULL,
//                                      3 BAD_ID
//               node_count             allocated nodes including root
// Revision    : 1.0 - initial release
// ============================================================================
module tree_path_engine
  import tree_engine_pkg::*;
#(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE  = 8,
  parameter int MAX_NODES       = 64,
  parameter int MAX_CHILDREN    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [IDENTIFIER_SIZE-1:0] cmd_id,
  input  logic                       cmd_last,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_hit,
  output logic [NODE_ADDR_SIZE-1:0]  rsp_addr,
  output logic [1:0]                 rsp_err,
  output logic [NODE_ADDR_SIZE:0]    node_count
);

  localparam int SLOT_W = (MAX_CHILDREN > 1) ? $clog2(MAX_CHILDREN) : 1;
  localparam logic [NODE_ADDR_SIZE:0] C_MAX_NODES = (NODE_ADDR_SIZE+1)'(MAX_NODES);

  // Registered state
  state_e                     state_q, state_d;
  logic [NODE_ADDR_SIZE-1:0]  cur_q, cur_d;
  op_e                        op_q, op_d;
  logic [IDENTIFIER_SIZE-1:0] id_q, id_d;
  logic                       last_q, last_d;
  logic [SLOT_W-1:0]          k_q, k_d;
  logic                       hit_q, hit_d;
  logic                       miss_q, miss_d;
  err_e                       err_q, err_d;
  logic                       first_q, first_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic [NODE_ADDR_SIZE:0]    count_q, count_d;

  // Table interface
  logic [NODE_ADDR_SIZE-1:0]  rd_child_addr;
  logic [IDENTIFIER_SIZE-1:0] rd_child_id;
  logic                       wr_en;
  logic [NODE_ADDR_SIZE-1:0]  new_addr;

  logic fire;
  logic bad_id;
  logic slot_empty;
  logic slot_match;
  logic last_slot;
  logic table_full;

  tree_node_table #(
    .IDENTIFIER_SIZE (IDENTIFIER_SIZE),
    .NODE_ADDR_SIZE  (NODE_ADDR_SIZE),
    .MAX_NODES       (MAX_NODES),
    .MAX_CHILDREN    (MAX_CHILDREN)
  ) u_table (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (clear),
    .rd_node_i       (cur_q),
    .rd_slot_i       (k_q),
    .rd_child_addr_o (rd_child_addr),
    .rd_child_id_o   (rd_child_id),
    .wr_en_i         (wr_en),
    .wr_node_i       (new_addr),
    .wr_id_i         (id_q),
    .wr_parent_i     (cur_q),
    .wr_slot_i       (k_q)
  );

  assign fire       = cmd_valid && cmd_ready_q;
  assign bad_id     = (cmd_id == '0);
  assign slot_empty = slot_is_empty(PKG_ADDR_W_MAX'(rd_child_addr));
  assign slot_match = !slot_empty && (rd_child_id == id_q);
  assign last_slot  = slot_is_last(32'(k_q), 32'(MAX_CHILDREN));
  assign table_full = (count_q == C_MAX_NODES);
  // node_count < MAX_NODES whenever ALLOC is reached, so it fits the address.
  assign new_addr   = count_q[NODE_ADDR_SIZE-1:0];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    k_d     = k_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    err_d   = err_q;
    first_d = first_q;
    count_d = count_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          last_d = cmd_last;
          if (first_q) begin
            op_d    = op_e'(cmd_op);
            hit_d   = 1'b1;
            first_d = 1'b0;
          end
          if (bad_id) begin
            err_d   = ERR_BAD_ID;
            hit_d   = 1'b0;
            state_d = cmd_last ? ST_RESP : ST_DRAIN;
          end else begin
            id_d    = cmd_id;
            k_d     = '0;
            state_d = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (slot_match) begin
          cur_d   = rd_child_addr;
          state_d = last_q ? ST_RESP : ST_IDLE;
        end else if (slot_empty || last_slot) begin
          // Slots fill densely, so an empty slot ends the search early.
          if (op_q == OP_LOOKUP) begin
            hit_d   = 1'b0;
            miss_d  = 1'b1;
            state_d = last_q ? ST_RESP : ST_DRAIN;
          end else if (table_full) begin
            err_d   = ERR_TABLE_FULL;
            hit_d   = 1'b0;
            state_d = last_q ? ST_RESP : ST_DRAIN;
          end else if (!slot_empty) begin
            err_d   = ERR_FANOUT_FULL;
            hit_d   = 1'b0;
            state_d = last_q ? ST_RESP : ST_DRAIN;
          end else begin
            // k_q stays on the empty slot that ALLOC links into.
            state_d = ST_ALLOC;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_ALLOC: begin
        wr_en   = 1'b1;
        cur_d   = new_addr;
        count_d = count_q + 1'b1;
        hit_d   = 1'b0;
        state_d = last_q ? ST_RESP : ST_IDLE;
      end

      ST_DRAIN: begin
        if (fire) begin
          if (bad_id && (err_q == ERR_OK)) begin
            err_d = ERR_BAD_ID;
            hit_d = 1'b0;
          end
          if (cmd_last) state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          err_d   = ERR_OK;
          miss_d  = 1'b0;
          hit_d   = 1'b0;
          first_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      op_q        <= OP_LOOKUP;
      id_q        <= '0;
      last_q      <= 1'b0;
      k_q         <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      err_q       <= ERR_OK;
      first_q     <= 1'b1;
      cmd_ready_q <= 1'b0;
      count_q     <= (NODE_ADDR_SIZE+1)'(1);
    end else if (clear) begin
      // Same as reset, except the engine is immediately ready for beats.
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      op_q        <= OP_LOOKUP;
      id_q        <= '0;
      last_q      <= 1'b0;
      k_q         <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      err_q       <= ERR_OK;
      first_q     <= 1'b1;
      cmd_ready_q <= 1'b1;
      count_q     <= (NODE_ADDR_SIZE+1)'(1);
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      op_q        <= op_d;
      id_q        <= id_d;
      last_q      <= last_d;
      k_q         <= k_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      first_q     <= first_d;
      cmd_ready_q <= cmd_ready_d;
      count_q     <= count_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_hit    = rsp_valid && hit_q;
  assign rsp_err    = rsp_valid ? err_q : ERR_OK;
  assign rsp_addr   = (rsp_valid && (err_q == ERR_OK) && !miss_q) ? cur_q : '0;
  assign node_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_path_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_path_engine
// Description : Directed bench for tree_path_engine. Instance 0 uses default
//               parameters; instance 1 uses MAX_NODES=4 for table-full cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_path_engine;
  import tree_engine_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear      [2];
  logic       cmd_valid  [2];
  logic       cmd_ready  [2];
  logic       cmd_op     [2];
  logic [7:0] cmd_id     [2];
  logic       cmd_last   [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic       rsp_hit    [2];
  logic [7:0] rsp_addr   [2];
  logic [1:0] rsp_err    [2];
  logic [8:0] node_count [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tree_path_engine dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_id(cmd_id[0]), .cmd_last(cmd_last[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_hit(rsp_hit[0]),
    .rsp_addr(rsp_addr[0]), .rsp_err(rsp_err[0]), .node_count(node_count[0])
  );

  tree_path_engine #(.MAX_NODES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_id(cmd_id[1]), .cmd_last(cmd_last[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_hit(rsp_hit[1]),
    .rsp_addr(rsp_addr[1]), .rsp_err(rsp_err[1]), .node_count(node_count[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_beat(input int u, input bit op, input logic [7:0] id, input bit last);
    int n = 0;
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_id[u]    = id;
    cmd_last[u]  = last;
    while (!cmd_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("cmd_ready_timeout", 32'(cmd_ready[u]), 32'd1);
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    cmd_last[u]  = 1'b0;
  endtask

  task automatic send_path(input int u, input bit op, input int n,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] id;
    for (int i = 0; i < n; i++) begin
      id = (i == 0) ? a : ((i == 1) ? b : c);
      send_beat(u, op, id, (i == n - 1));
    end
  endtask

  task automatic get_rsp(input int u, input string tag, input bit eh,
                         input logic [7:0] ea, input logic [1:0] ee);
    int n = 0;
    while (!rsp_valid[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid[u]), 32'd1);
    chk({tag, "_hit"},   32'(rsp_hit[u]),   32'(eh));
    chk({tag, "_addr"},  32'(rsp_addr[u]),  32'(ea));
    chk({tag, "_err"},   32'(rsp_err[u]),   32'(ee));
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      clear[u] = 1'b0; cmd_valid[u] = 1'b0; cmd_op[u] = 1'b0;
      cmd_id[u] = '0; cmd_last[u] = 1'b0; rsp_ready[u] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready",  32'(cmd_ready[0]),  32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid[0]),  32'd0);
    chk("rst_node_count", 32'(node_count[0]), 32'd1);
    chk("rst_rsp_addr",   32'(rsp_addr[0]),   32'd0);
    rst_n = 1'b1;
    chk("rel_cmd_ready_low", 32'(cmd_ready[0]), 32'd0);
    @(negedge clk);
    chk("rel_cmd_ready_high", 32'(cmd_ready[0]), 32'd1);

    // INSERT {5,7,9} into empty table
    send_path(0, 1'b1, 3, 8'd5, 8'd7, 8'd9);
    get_rsp(0, "ins579", 1'b0, 8'd3, 2'd0);
    chk("ins579_count",   32'(node_count[0]), 32'd4);
    chk("node3_parent",   32'(dut0.u_table.nodes_q[3].parent),   32'd2);
    chk("node3_id",       32'(dut0.u_table.nodes_q[3].id),       32'd9);
    chk("root_slot0",     32'(dut0.u_table.nodes_q[0].child[0]), 32'd1);
    chk("node1_slot0",    32'(dut0.u_table.nodes_q[1].child[0]), 32'd2);

    // Re-INSERT existing path, then LOOKUPs
    send_path(0, 1'b1, 3, 8'd5, 8'd7, 8'd9);
    get_rsp(0, "reins579", 1'b1, 8'd3, 2'd0);
    chk("reins_count", 32'(node_count[0]), 32'd4);
    send_path(0, 1'b0, 2, 8'd5, 8'd7, 8'd0);
    get_rsp(0, "lk57", 1'b1, 8'd2, 2'd0);
    send_path(0, 1'b0, 2, 8'd5, 8'd8, 8'd0);
    get_rsp(0, "lk58", 1'b0, 8'd0, 2'd0);
    chk("lk_count", 32'(node_count[0]), 32'd4);

    // Match in slot 0 answers one cycle after acceptance
    send_path(0, 1'b0, 1, 8'd5, 8'd0, 8'd0);
    chk("lat_early", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    chk("lat_k0", 32'(rsp_valid[0]), 32'd1);
    get_rsp(0, "lk5", 1'b1, 8'd1, 2'd0);

    // Fill root to 4 children, then a 5th sibling path overflows fanout
    send_path(0, 1'b1, 1, 8'd20, 8'd0, 8'd0);
    get_rsp(0, "ins20", 1'b0, 8'd4, 2'd0);
    send_path(0, 1'b1, 1, 8'd21, 8'd0, 8'd0);
    get_rsp(0, "ins21", 1'b0, 8'd5, 2'd0);
    send_path(0, 1'b1, 1, 8'd22, 8'd0, 8'd0);
    get_rsp(0, "ins22", 1'b0, 8'd6, 2'd0);
    chk("sib_count", 32'(node_count[0]), 32'd7);
    send_path(0, 1'b1, 3, 8'd11, 8'd12, 8'd13);
    get_rsp(0, "fanout", 1'b0, 8'd0, 2'd2);
    chk("fanout_count", 32'(node_count[0]), 32'd7);
    chk("fanout_slot3", 32'(dut0.u_table.nodes_q[0].child[3]), 32'd6);

    // Zero identifier mid-path
    send_path(0, 1'b0, 2, 8'd5, 8'd0, 8'd0);
    get_rsp(0, "badid0", 1'b0, 8'd0, 2'd3);

    // Response held while rsp_ready is low
    send_path(0, 1'b1, 1, 8'd5, 8'd0, 8'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("hold_addr",  32'(rsp_addr[0]),  32'd1);
      chk("hold_ready", 32'(cmd_ready[0]), 32'd0);
      @(negedge clk);
    end
    get_rsp(0, "hold", 1'b1, 8'd1, 2'd0);
    chk("post_rsp_ready", 32'(cmd_ready[0]), 32'd1);

    // MAX_NODES=4 instance: table full and bad id
    send_path(1, 1'b1, 1, 8'd1, 8'd0, 8'd0);
    get_rsp(1, "t4_ins1", 1'b0, 8'd1, 2'd0);
    send_path(1, 1'b1, 1, 8'd2, 8'd0, 8'd0);
    get_rsp(1, "t4_ins2", 1'b0, 8'd2, 2'd0);
    send_path(1, 1'b1, 1, 8'd3, 8'd0, 8'd0);
    get_rsp(1, "t4_ins3", 1'b0, 8'd3, 2'd0);
    send_path(1, 1'b1, 1, 8'd4, 8'd0, 8'd0);
    get_rsp(1, "t4_full", 1'b0, 8'd0, 2'd1);
    chk("t4_count", 32'(node_count[1]), 32'd4);
    send_path(1, 1'b1, 1, 8'd1, 8'd0, 8'd0);
    get_rsp(1, "t4_exist", 1'b1, 8'd1, 2'd0);
    send_path(1, 1'b0, 1, 8'd0, 8'd0, 8'd0);
    get_rsp(1, "t4_badid", 1'b0, 8'd0, 2'd3);

    // Clear mid-SCAN (id 22 lives in slot 3, so the scan is still running)
    send_path(0, 1'b0, 1, 8'd22, 8'd0, 8'd0);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    chk("clr_count", 32'(node_count[0]), 32'd1);
    chk("clr_ready", 32'(cmd_ready[0]), 32'd1);
    repeat (6) @(negedge clk);
    chk("clr_no_rsp", 32'(rsp_valid[0]), 32'd0);
    chk("clr_root_slot3", 32'(dut0.u_table.nodes_q[0].child[3]), 32'd0);
    chk("clr_node6_id", 32'(dut0.u_table.nodes_q[6].id), 32'd0);

    // Reset mid-ALLOC
    send_path(0, 1'b1, 1, 8'd5, 8'd0, 8'd0);
    @(negedge clk);
    chk("pre_rst_alloc", 32'(dut0.state_q), 32'(ST_ALLOC));
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst_count", 32'(node_count[0]), 32'd1);
    chk("arst_node1_id", 32'(dut0.u_table.nodes_q[1].id), 32'd0);
    chk("arst_root_slot0", 32'(dut0.u_table.nodes_q[0].child[0]), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_rsp", 32'(rsp_valid[0]), 32'd0);
    chk("arst_count2", 32'(node_count[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
